// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding controller: shift scoreboard of in-flight writers; resolves
// decode sources to stall or forwarding slot. Forwarding enabled by PIPELINE_FORWARDING_EN.
// Ports: clock, resetN (async low), hold, dec* (decode bundle),
//        stall, fwd1Sel, fwd2Sel, stallCount (saturating).
module pipeline_hazard_scoreboard #(
  parameter int REG_ID_WIDTH = 5,
  parameter int DEPTH        = 3,
  parameter int STAGE_WIDTH  = $clog2(DEPTH+1),
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    hold,
  input  logic                    decValid,
  input  logic [REG_ID_WIDTH-1:0] decRead1Id,
  input  logic [REG_ID_WIDTH-1:0] decRead2Id,
  input  logic [STAGE_WIDTH-1:0]  decRequiredStage,
  input  logic                    decWriteEnabled,
  input  logic [REG_ID_WIDTH-1:0] decWriteId,
  input  logic [STAGE_WIDTH-1:0]  decReadyStage,
  output logic                    stall,
  output logic [STAGE_WIDTH-1:0]  fwd1Sel,
  output logic [STAGE_WIDTH-1:0]  fwd2Sel,
  output logic [CNT_WIDTH-1:0]    stallCount
);

  // one extra bit so k+R never overflows
  localparam int SW1 = STAGE_WIDTH + 1;
  localparam logic [SW1-1:0] L_DEPTH = SW1'(DEPTH);

  logic [DEPTH:1]          r_valid;
  logic [REG_ID_WIDTH-1:0] r_wid [1:DEPTH];
  logic [CNT_WIDTH-1:0]    r_cnt;

  logic [REG_ID_WIDTH-1:0] w_id [2];
  logic [1:0]              w_stall_src;
  logic                    w_hit;
  logic [SW1-1:0]          w_k;
  logic [SW1-1:0]          w_sum;
  logic                    w_act;
  logic                    w_push;

`ifdef PIPELINE_FORWARDING_EN
  logic [STAGE_WIDTH-1:0]  r_rdy [1:DEPTH];
  logic [SW1-1:0]          w_p;
  logic [STAGE_WIDTH-1:0]  w_sel [2];
`else
  logic                    w_unused;
  assign w_unused = ^decReadyStage;
`endif

  assign w_id[0] = decRead1Id;
  assign w_id[1] = decRead2Id;

  always_comb begin
    w_stall_src = '0;
    w_hit       = 1'b0;
    w_k         = '0;
    w_sum       = '0;
    w_act       = 1'b0;
`ifdef PIPELINE_FORWARDING_EN
    w_p         = '0;
    w_sel[0]    = '0;
    w_sel[1]    = '0;
`endif
    for (int s = 0; s < 2; s++) begin
      w_hit = 1'b0;
      w_k   = '0;
`ifdef PIPELINE_FORWARDING_EN
      w_p   = '0;
`endif
      // scan oldest to youngest so the youngest match wins
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_valid[k] && r_wid[k] == w_id[s]) begin
          w_hit = 1'b1;
          w_k   = SW1'(k);
`ifdef PIPELINE_FORWARDING_EN
          w_p   = {1'b0, r_rdy[k]};
`endif
        end
      end
      w_act = decValid && (w_id[s] != '0)
              && ({1'b0, decRequiredStage} <= L_DEPTH);
      w_sum = w_k + {1'b0, decRequiredStage};
      // k+R beyond DEPTH: writer has retired, register file is current
      if (w_act && w_hit && w_sum <= L_DEPTH) begin
`ifdef PIPELINE_FORWARDING_EN
        if (w_sum > w_p)
          w_sel[s] = w_sum[STAGE_WIDTH-1:0];
        else
          w_stall_src[s] = 1'b1;
`else
        w_stall_src[s] = 1'b1;
`endif
      end
    end
  end

  assign stall = |w_stall_src;

`ifdef PIPELINE_FORWARDING_EN
  assign fwd1Sel = stall ? '0 : w_sel[0];
  assign fwd2Sel = stall ? '0 : w_sel[1];
`else
  assign fwd1Sel = '0;
  assign fwd2Sel = '0;
`endif

  assign w_push = decValid && !stall && decWriteEnabled
                  && (decWriteId != '0);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_wid[k] <= '0;
`ifdef PIPELINE_FORWARDING_EN
        r_rdy[k] <= '0;
`endif
      end
    end else if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_wid[k]   <= r_wid[k-1];
`ifdef PIPELINE_FORWARDING_EN
        r_rdy[k]   <= r_rdy[k-1];
`endif
      end
      r_valid[1] <= w_push;
      r_wid[1]   <= decWriteId;
`ifdef PIPELINE_FORWARDING_EN
      r_rdy[1]   <= decReadyStage;
`endif
      if (stall && r_cnt != '1)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign stallCount = r_cnt;

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed testbench for pipeline_hazard_scoreboard.
// Expectations follow the build's PIPELINE_FORWARDING_EN setting.
module tb_pipeline_hazard_scoreboard;

  logic        clock;
  logic        resetN;
  logic        hold;
  logic        decValid;
  logic [4:0]  decRead1Id;
  logic [4:0]  decRead2Id;
  logic [1:0]  decRequiredStage;
  logic        decWriteEnabled;
  logic [4:0]  decWriteId;
  logic [1:0]  decReadyStage;
  logic        stall;
  logic [1:0]  fwd1Sel;
  logic [1:0]  fwd2Sel;
  logic [31:0] stallCount;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_scoreboard dut (
    .clock            (clock),
    .resetN           (resetN),
    .hold             (hold),
    .decValid         (decValid),
    .decRead1Id       (decRead1Id),
    .decRead2Id       (decRead2Id),
    .decRequiredStage (decRequiredStage),
    .decWriteEnabled  (decWriteEnabled),
    .decWriteId       (decWriteId),
    .decReadyStage    (decReadyStage),
    .stall            (stall),
    .fwd1Sel          (fwd1Sel),
    .fwd2Sel          (fwd2Sel),
    .stallCount       (stallCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic [4:0] a,
                       input logic [4:0] b, input logic [1:0] r,
                       input logic we, input logic [4:0] wid,
                       input logic [1:0] p);
    decValid         = v;
    decRead1Id       = a;
    decRead2Id       = b;
    decRequiredStage = r;
    decWriteEnabled  = we;
    decWriteId       = wid;
    decReadyStage    = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic writer(input logic [4:0] wid, input logic [1:0] p);
    drive(1'b1, 5'd0, 5'd0, 2'd3, 1'b1, wid, p);
    tick();
  endtask

  task automatic apply_reset();
    hold   = 1'b0;
    resetN = 1'b0;
    idle();
    tick();
    resetN = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd0 || fwd2Sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_out stall=%b f1=%0d f2=%0d want 0 0 0",
               stall, fwd1Sel, fwd2Sel);
    end
    checks++;
    if (stallCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d want=0", stallCount);
    end
  endtask

  task automatic test_alu_fwd();
    apply_reset();
    writer(5'd3, 2'd1);
    drive(1'b1, 5'd3, 5'd0, 2'd1, 1'b0, 5'd0, 2'd0);
`ifdef PIPELINE_FORWARDING_EN
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd2 || fwd2Sel !== 2'd0) begin
      errors++;
      $display("FAIL alu_fwd stall=%b f1=%0d f2=%0d want 0 2 0",
               stall, fwd1Sel, fwd2Sel);
    end
`else
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL alu_stall%0d got=%b want=1", c, stall);
      end
      tick();
    end
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd0 || stallCount !== 32'd2) begin
      errors++;
      $display("FAIL alu_rel stall=%b f1=%0d cnt=%0d want 0 0 2",
               stall, fwd1Sel, stallCount);
    end
`endif
  endtask

  task automatic test_load_use();
    apply_reset();
    writer(5'd4, 2'd2);
    drive(1'b1, 5'd4, 5'd4, 2'd1, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b1 || fwd1Sel !== 2'd0 || fwd2Sel !== 2'd0) begin
      errors++;
      $display("FAIL load_c0 stall=%b f1=%0d f2=%0d want 1 0 0",
               stall, fwd1Sel, fwd2Sel);
    end
    tick();
`ifdef PIPELINE_FORWARDING_EN
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd3 || fwd2Sel !== 2'd3
        || stallCount !== 32'd1) begin
      errors++;
      $display("FAIL load_c1 stall=%b f1=%0d f2=%0d cnt=%0d want 0 3 3 1",
               stall, fwd1Sel, fwd2Sel, stallCount);
    end
`else
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL load_c1 got=%b want=1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd0 || stallCount !== 32'd2) begin
      errors++;
      $display("FAIL load_c2 stall=%b f1=%0d cnt=%0d want 0 0 2",
               stall, fwd1Sel, stallCount);
    end
`endif
  endtask

  task automatic test_branch();
    apply_reset();
    writer(5'd5, 2'd1);
    drive(1'b1, 5'd0, 5'd5, 2'd0, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL br_c0 got=%b want=1", stall);
    end
    tick();
`ifdef PIPELINE_FORWARDING_EN
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd0 || fwd2Sel !== 2'd2
        || stallCount !== 32'd1) begin
      errors++;
      $display("FAIL br_c1 stall=%b f1=%0d f2=%0d cnt=%0d want 0 0 2 1",
               stall, fwd1Sel, fwd2Sel, stallCount);
    end
`else
    tick();
    tick();
    checks++;
    if (stall !== 1'b0 || fwd2Sel !== 2'd0 || stallCount !== 32'd3) begin
      errors++;
      $display("FAIL br_c3 stall=%b f2=%0d cnt=%0d want 0 0 3",
               stall, fwd2Sel, stallCount);
    end
`endif
  endtask

  task automatic test_youngest();
    apply_reset();
    writer(5'd6, 2'd1);
    writer(5'd6, 2'd1);
    drive(1'b1, 5'd6, 5'd0, 2'd1, 1'b0, 5'd0, 2'd0);
`ifdef PIPELINE_FORWARDING_EN
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd2 || fwd2Sel !== 2'd0) begin
      errors++;
      $display("FAIL young stall=%b f1=%0d f2=%0d want 0 2 0",
               stall, fwd1Sel, fwd2Sel);
    end
`else
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL young got=%b want=1", stall);
    end
`endif
    drive(1'b1, 5'd0, 5'd0, 2'd1, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd0 || fwd2Sel !== 2'd0) begin
      errors++;
      $display("FAIL r0_read stall=%b f1=%0d f2=%0d want 0 0 0",
               stall, fwd1Sel, fwd2Sel);
    end
    drive(1'b0, 5'd6, 5'd6, 2'd1, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL invalid_dec got=%b want=0", stall);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    writer(5'd4, 2'd2);
    drive(1'b1, 5'd4, 5'd0, 2'd1, 1'b0, 5'd0, 2'd0);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (stall !== 1'b1 || stallCount !== 32'd0) begin
        errors++;
        $display("FAIL hold%0d stall=%b cnt=%0d want 1 0",
                 c, stall, stallCount);
      end
    end
    hold = 1'b0;
    #1;
    tick();
`ifdef PIPELINE_FORWARDING_EN
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd3 || stallCount !== 32'd1) begin
      errors++;
      $display("FAIL hold_rel stall=%b f1=%0d cnt=%0d want 0 3 1",
               stall, fwd1Sel, stallCount);
    end
`else
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL hold_rel got=%b want=1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || stallCount !== 32'd2) begin
      errors++;
      $display("FAIL hold_end stall=%b cnt=%0d want 0 2",
               stall, stallCount);
    end
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    writer(5'd7, 2'd0);
    drive(1'b1, 5'd7, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
`ifdef PIPELINE_FORWARDING_EN
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd1) begin
      errors++;
      $display("FAIL b2b stall=%b f1=%0d want 0 1", stall, fwd1Sel);
    end
`else
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b got=%b want=1", stall);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    writer(5'd1, 2'd3);
    writer(5'd2, 2'd3);
    writer(5'd3, 2'd3);
    drive(1'b1, 5'd3, 5'd0, 2'd1, 1'b0, 5'd0, 2'd0);
    tick();
    checks++;
    if (stallCount !== 32'd1) begin
      errors++;
      $display("FAIL mid_cnt got=%0d want=1", stallCount);
    end
    resetN = 1'b0;
    #1;
    checks++;
    if (stallCount !== 32'd0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL async_rst cnt=%0d stall=%b want 0 0",
               stallCount, stall);
    end
    tick();
    resetN = 1'b1;
    drive(1'b1, 5'd3, 5'd2, 2'd1, 1'b0, 5'd0, 2'd0);
    tick();
    checks++;
    if (stall !== 1'b0 || fwd1Sel !== 2'd0 || fwd2Sel !== 2'd0
        || stallCount !== 32'd0) begin
      errors++;
      $display("FAIL post_rst stall=%b f1=%0d f2=%0d cnt=%0d want 0 0 0 0",
               stall, fwd1Sel, fwd2Sel, stallCount);
    end
  endtask

  initial begin
    hold   = 1'b0;
    resetN = 1'b0;
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_youngest();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
